// File: rtl/alu_issue_pkg.sv
// Shared definitions for the execute-stage issue sequencer: ALU function codes,
// RV32I opcode/funct constants, FSM states and the immediate bundle.
package alu_issue_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] u;
        logic [31:0] j;
    } imm_t;

    // Compare function for a branch: equality via subtract, ordering via set-less-than.
    function automatic alu_fn_e branch_fn(input logic [2:0] f3);
        alu_fn_e fn;
        case (f3[2:1])
            2'b00:   fn = ALU_SUB;
            2'b10:   fn = ALU_SLT;
            2'b11:   fn = ALU_SLTU;
            default: fn = ALU_ADD;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/alu_issue_imm_gen.sv
// Immediate generator: all RV32I immediate formats, sign-extended to 32 bits.
// Latency: combinational. Backpressure: none.
// Flow control: pure function of the instruction word, no handshake.
module alu_issue_imm_gen
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    output imm_t        imm
);

    always_comb begin
        imm.i = {{20{instr[31]}}, instr[31:20]};
        imm.s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm.b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm.u = {instr[31:12], 12'b0};
        imm.j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage sequencer: decodes one RV32I op, drives an external ALU for one or two passes.
// Latency: record valid 2 edges after accept (single pass), 3 for branch/JAL/JALR.
// Backpressure: record held stable in HOLD until out_ready; in_ready only in IDLE.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int FN_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic [XLEN-1:0] alu_x,
    output logic [XLEN-1:0] alu_y,
    output logic [FN_W-1:0] alu_fn,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic [XLEN-1:0] out_result,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal
);

    state_e          state_q, state_d;
    logic [6:0]      opc_q;
    logic [2:0]      f3_q;
    logic [6:0]      f7_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;

    imm_t            imm;
    logic [31:0]     imm_sel;
    logic            imm_unused;

    logic            illegal;
    logic            two_pass;
    logic            is_branch;
    logic            is_jump;
    logic            taken;
    alu_fn_e         op_fn;
    alu_fn_e         fn_c;

    alu_issue_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    assign imm_unused = ^imm.s;

    // Only one immediate format matters per opcode, so a single register carries it.
    always_comb begin
        case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC: imm_sel = imm.u;
            OPC_JAL:            imm_sel = imm.j;
            OPC_BRANCH:         imm_sel = imm.b;
            default:            imm_sel = imm.i;
        endcase
    end

    always_comb begin
        illegal   = 1'b0;
        two_pass  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        op_fn     = ALU_ADD;
        case (opc_q)
            OPC_LUI, OPC_AUIPC: op_fn = ALU_ADD;
            OPC_JAL, OPC_JALR: begin
                is_jump  = 1'b1;
                two_pass = 1'b1;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                two_pass  = 1'b1;
                op_fn     = branch_fn(f3_q);
                illegal   = (f3_q[2:1] == 2'b01);
            end
            OPC_OP_IMM: begin
                op_fn = alu_fn_e'({1'b0, f3_q});
                if ((f3_q == F3_SLL || f3_q == F3_SRL) && f7_q != F7_ZERO)
                    illegal = 1'b1;
            end
            OPC_OP: begin
                op_fn = alu_fn_e'({1'b0, f3_q});
                if (f7_q == F7_ALT && f3_q == F3_ADD)
                    op_fn = ALU_SUB;
                else if (f7_q != F7_ZERO)
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal)
            two_pass = 1'b0;
    end

    // funct3[2] picks ordering vs equality; funct3[0] inverts the sense.
    assign taken = (f3_q[2] ? alu_out[0] : alu_zero) ^ f3_q[0];

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_OP1;
            ST_OP1:  state_d = two_pass ? ST_OP2 : ST_HOLD;
            ST_OP2:  state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE) && rst_n;
        alu_x    = '0;
        alu_y    = '0;
        fn_c     = ALU_ADD;
        if (state_q == ST_OP1 && !illegal) begin
            fn_c = op_fn;
            case (opc_q)
                OPC_LUI:            alu_y = imm_q;
                OPC_AUIPC: begin
                    alu_x = pc_q;
                    alu_y = imm_q;
                end
                OPC_JAL, OPC_JALR: begin
                    alu_x = pc_q;
                    alu_y = XLEN'(4);
                end
                OPC_OP_IMM: begin
                    alu_x = rs1_q;
                    alu_y = imm_q;
                end
                default: begin
                    alu_x = rs1_q;
                    alu_y = rs2_q;
                end
            endcase
        end else if (state_q == ST_OP2) begin
            alu_x = (opc_q == OPC_JALR) ? rs1_q : pc_q;
            alu_y = imm_q;
        end
    end

    assign alu_fn = fn_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opc_q         <= '0;
            f3_q          <= '0;
            f7_q          <= '0;
            rd_q          <= '0;
            pc_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_q         <= '0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_we        <= 1'b0;
            out_result    <= '0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            out_illegal   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        opc_q <= in_instr[6:0];
                        f3_q  <= in_instr[14:12];
                        f7_q  <= in_instr[31:25];
                        rd_q  <= in_instr[11:7];
                        pc_q  <= in_pc;
                        rs1_q <= in_rs1;
                        rs2_q <= in_rs2;
                        imm_q <= imm_sel;
                    end
                end
                ST_OP1: begin
                    out_rd        <= rd_q;
                    out_we        <= !illegal && !is_branch && (rd_q != 5'd0);
                    out_result    <= (illegal || is_branch) ? '0 : alu_out;
                    out_illegal   <= illegal;
                    out_br_taken  <= !illegal && (is_branch ? taken : is_jump);
                    out_br_target <= '0;
                    out_valid     <= !two_pass;
                end
                ST_OP2: begin
                    if (out_br_taken)
                        out_br_target <= (opc_q == OPC_JALR) ? {alu_out[XLEN-1:1], 1'b0} : alu_out;
                    out_valid <= 1'b1;
                end
                default: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU alongside the DUT.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
    logic [31:0] alu_x, alu_y, alu_out;
    logic [3:0]  alu_fn;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [31:0] out_result;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    logic [3:0]  s_fn;
    logic [31:0] s_x, s_y;
    int          lat;

    alu_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .alu_x         (alu_x),
        .alu_y         (alu_y),
        .alu_fn        (alu_fn),
        .alu_out       (alu_out),
        .alu_zero      (alu_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_result    (out_result),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .out_illegal   (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_fn)
            4'd0:    alu_out = alu_x + alu_y;
            4'd1:    alu_out = alu_x << alu_y[4:0];
            4'd2:    alu_out = {31'b0, $signed(alu_x) < $signed(alu_y)};
            4'd3:    alu_out = {31'b0, alu_x < alu_y};
            4'd4:    alu_out = alu_x ^ alu_y;
            4'd5:    alu_out = alu_x >> alu_y[4:0];
            4'd6:    alu_out = alu_x | alu_y;
            4'd7:    alu_out = alu_x & alu_y;
            4'd8:    alu_out = alu_x - alu_y;
            default: alu_out = 32'h0;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    // Present one op, wait for the accept edge, then sample the OP1 ALU drive.
    task automatic drive_accept(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        in_rs1   = rs1;
        in_rs2   = rs2;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        s_fn = alu_fn;
        s_x  = alu_x;
        s_y  = alu_y;
    endtask

    // lat = number of accept-relative edges until out_valid is sampled high.
    task automatic wait_valid();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_rec();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
        checks++; if (alu_fn !== 4'd0) begin errors++; $display("FAIL reset_alu_fn: got %0d, required 0", alu_fn); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 0", out_result); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_addi();
        drive_accept(32'hFFF00293, 32'h0, 32'h0, 32'h0);
        checks++; if (s_fn !== 4'd0) begin errors++; $display("FAIL addi_fn: got %0d, required 0", s_fn); end
        checks++; if (s_y !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_y: got %h, required ffffffff", s_y); end
        wait_valid();
        checks++; if (lat !== 2) begin errors++; $display("FAIL addi_latency: got %0d, required 2", lat); end
        checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d, required 5", out_rd); end
        checks++; if (out_we !== 1'b1) begin errors++; $display("FAIL addi_we: got %b, required 1", out_we); end
        checks++; if (out_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_result: got %h, required ffffffff", out_result); end
        checks++; if (out_br_taken !== 1'b0 || out_illegal !== 1'b0) begin errors++; $display("FAIL addi_flags: got taken=%b illegal=%b, required 0/0", out_br_taken, out_illegal); end
        release_rec();
    endtask

    task automatic test_alu_ops();
        // SUB x3,x1,x2
        drive_accept(32'h402081B3, 32'h0, 32'd5, 32'd7);
        checks++; if (s_fn !== 4'd8) begin errors++; $display("FAIL sub_fn: got %0d, required 8", s_fn); end
        wait_valid();
        checks++; if (out_result !== 32'hFFFFFFFE || out_rd !== 5'd3) begin errors++; $display("FAIL sub_result: got %h rd=%0d, required fffffffe rd=3", out_result, out_rd); end
        release_rec();
        // SLT x4,x1,x2
        drive_accept(32'h0020A233, 32'h0, 32'h80000000, 32'd1);
        checks++; if (s_fn !== 4'd2) begin errors++; $display("FAIL slt_fn: got %0d, required 2", s_fn); end
        wait_valid();
        checks++; if (out_result !== 32'd1) begin errors++; $display("FAIL slt_result: got %h, required 1", out_result); end
        release_rec();
        // SLTU x4,x1,x2
        drive_accept(32'h0020B233, 32'h0, 32'h80000000, 32'd1);
        checks++; if (s_fn !== 4'd3) begin errors++; $display("FAIL sltu_fn: got %0d, required 3", s_fn); end
        wait_valid();
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL sltu_result: got %h, required 0", out_result); end
        release_rec();
        // AUIPC x7,0x12345
        drive_accept(32'h12345397, 32'h100, 32'h0, 32'h0);
        checks++; if (s_x !== 32'h100 || s_y !== 32'h12345000) begin errors++; $display("FAIL auipc_operands: got x=%h y=%h, required 100/12345000", s_x, s_y); end
        wait_valid();
        checks++; if (out_result !== 32'h12345100 || out_rd !== 5'd7) begin errors++; $display("FAIL auipc_result: got %h rd=%0d, required 12345100 rd=7", out_result, out_rd); end
        release_rec();
    endtask

    task automatic test_branch();
        // BEQ x1,x2,+16
        drive_accept(32'h00208863, 32'h100, 32'd9, 32'd9);
        checks++; if (s_fn !== 4'd8) begin errors++; $display("FAIL beq_fn: got %0d, required 8", s_fn); end
        wait_valid();
        checks++; if (lat !== 3) begin errors++; $display("FAIL beq_latency: got %0d, required 3", lat); end
        checks++; if (out_br_taken !== 1'b1 || out_br_target !== 32'h110) begin errors++; $display("FAIL beq_redirect: got taken=%b target=%h, required 1/110", out_br_taken, out_br_target); end
        checks++; if (out_we !== 1'b0 || out_result !== 32'h0) begin errors++; $display("FAIL beq_wb: got we=%b result=%h, required 0/0", out_we, out_result); end
        release_rec();
        // BNE x1,x2,+16 with equal operands
        drive_accept(32'h00209863, 32'h100, 32'd9, 32'd9);
        wait_valid();
        checks++; if (out_br_taken !== 1'b0 || out_br_target !== 32'h0) begin errors++; $display("FAIL bne_redirect: got taken=%b target=%h, required 0/0", out_br_taken, out_br_target); end
        release_rec();
        // BLT x1,x2,+16: -1 < 1
        drive_accept(32'h0020C863, 32'h200, 32'hFFFFFFFF, 32'd1);
        wait_valid();
        checks++; if (out_br_taken !== 1'b1 || out_br_target !== 32'h210) begin errors++; $display("FAIL blt_redirect: got taken=%b target=%h, required 1/210", out_br_taken, out_br_target); end
        release_rec();
    endtask

    task automatic test_jumps();
        // JALR x1,8(x2)
        drive_accept(32'h008100E7, 32'h40, 32'h2003, 32'hDEADBEEF);
        wait_valid();
        checks++; if (lat !== 3) begin errors++; $display("FAIL jalr_latency: got %0d, required 3", lat); end
        checks++; if (out_result !== 32'h44 || out_we !== 1'b1) begin errors++; $display("FAIL jalr_link: got %h we=%b, required 44 we=1", out_result, out_we); end
        checks++; if (out_br_taken !== 1'b1 || out_br_target !== 32'h200A) begin errors++; $display("FAIL jalr_redirect: got taken=%b target=%h, required 1/200a", out_br_taken, out_br_target); end
        release_rec();
        // JAL x1,+0x20
        drive_accept(32'h020000EF, 32'h80, 32'h0, 32'h0);
        wait_valid();
        checks++; if (out_result !== 32'h84 || out_br_target !== 32'hA0) begin errors++; $display("FAIL jal: got link=%h target=%h, required 84/a0", out_result, out_br_target); end
        release_rec();
    endtask

    task automatic test_illegal();
        logic [31:0] vec [3];
        vec[0] = 32'h4030D093;  // SRAI x1,x1,3
        vec[1] = 32'h00012083;  // LW
        vec[2] = 32'h0020A863;  // BRANCH funct3 010
        for (int i = 0; i < 3; i++) begin
            drive_accept(vec[i], 32'h300, 32'd8, 32'd8);
            wait_valid();
            checks++;
            if (lat !== 2 || out_illegal !== 1'b1 || out_we !== 1'b0 || out_result !== 32'h0 || out_br_taken !== 1'b0)
            begin
                errors++;
                $display("FAIL illegal_%0d: got lat=%0d ill=%b we=%b res=%h taken=%b, required 2/1/0/0/0",
                         i, lat, out_illegal, out_we, out_result, out_br_taken);
            end
            release_rec();
        end
    endtask

    task automatic test_backpressure();
        // ADD x5,x1,x2
        drive_accept(32'h002082B3, 32'h0, 32'd3, 32'd4);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'd7 || out_rd !== 5'd5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got valid=%b res=%h rd=%0d in_ready=%b, required 1/7/5/0",
                         c, out_valid, out_result, out_rd, in_ready);
            end
        end
        release_rec();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got valid=%b in_ready=%b, required 0/1", out_valid, in_ready); end
    endtask

    task automatic test_x0_write();
        // ADD x0,x1,x2
        drive_accept(32'h00208033, 32'h0, 32'd3, 32'd4);
        wait_valid();
        checks++; if (out_we !== 1'b0 || out_rd !== 5'd0) begin errors++; $display("FAIL x0_we: got we=%b rd=%0d, required 0/0", out_we, out_rd); end
        release_rec();
    endtask

    task automatic test_reset_mid_op();
        drive_accept(32'h00208863, 32'h100, 32'd9, 32'd9);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in: got valid=%b in_ready=%b, required 0/0", out_valid, in_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release: got in_ready=%b, required 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_record_%0d: got valid=%b, required 0", c, out_valid); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        in_rs1    = 32'h0;
        in_rs2    = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_addi();
        test_alu_ops();
        test_branch();
        test_jumps();
        test_illegal();
        test_backpressure();
        test_x0_write();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
